con1_eval_sched: RTL and testbench

//  Round-robin scheduler that time-shares one con1 logic evaluator among NUM_REQ requesters.

---
 rtl/con1_sched_pkg.sv | 41 ++++
 rtl/con1_rr_arbiter.sv | 44 ++++
 rtl/con1_eval_sched.sv | 133 +++++++++++++
 tb/tb_con1_eval_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/con1_sched_pkg.sv
// ----------------------------------------------------------------------------
// con1_sched_pkg
//   Shared definitions for the con1 evaluation scheduler:
//   - state_t   : scheduler FSM states (IDLE, EVAL, RESP)
//   - *_BIT     : bit positions of the named operand fields inside the
//                 7-bit operand {a,b,c,d,f,g,h} (a at the MSB)
//   - con1_eval : pure function returning {f0,f1} for one operand
// ----------------------------------------------------------------------------
package con1_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int A_BIT = 6;
  localparam int B_BIT = 5;
  localparam int C_BIT = 4;
  localparam int D_BIT = 3;
  localparam int F_BIT = 2;
  localparam int G_BIT = 1;
  localparam int H_BIT = 0;

  // Returns {f0, f1}.
  function automatic logic [1:0] con1_eval(input logic [6:0] op);
    logic a, b, c, d, f, g, h;
    logic f0, f1;
    a  = op[A_BIT];
    b  = op[B_BIT];
    c  = op[C_BIT];
    d  = op[D_BIT];
    f  = op[F_BIT];
    g  = op[G_BIT];
    h  = op[H_BIT];
    f0 = (a & b) | (~b & ~c & d) | (c & d & f) | (b & h & ~f);
    f1 = (~a & ~b) | (~a & f) | (a & b & ~f) | (~f & ~g) | (f & ~b & ~d);
    return {f0, f1};
  endfunction

endpackage

// File: rtl/con1_rr_arbiter.sv
// ----------------------------------------------------------------------------
// con1_rr_arbiter
//   Combinational round-robin pick: returns the first asserted request at or
//   after rr_ptr, searching cyclically.
//   Ports:
//     req_valid [NUM_REQ-1:0] in  : per-requester request
//     rr_ptr    [ID_W-1:0]    in  : highest-priority index this cycle
//     any                     out : at least one request is asserted
//     grant_idx [ID_W-1:0]    out : chosen requester (0 when any=0)
// ----------------------------------------------------------------------------
module con1_rr_arbiter
  import con1_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any,
  output logic [ID_W-1:0]    grant_idx
);

  int              idx;
  logic [ID_W-1:0] sel;

  // Scan from the farthest offset down to offset 0 so the nearest valid
  // requester (in cyclic order from rr_ptr) is the last one written and wins.
  always_comb begin
    any       = 1'b0;
    grant_idx = '0;
    idx       = 0;
    sel       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (req_valid[sel]) begin
        any       = 1'b1;
        grant_idx = sel;
      end
    end
  end

endmodule

// File: rtl/con1_eval_sched.sv
// ----------------------------------------------------------------------------
// con1_eval_sched
//   Round-robin scheduler time-sharing one con1 evaluator among NUM_REQ
//   requesters. IDLE grants one request (one-cycle req_ready pulse) and
//   captures its operand, EVAL computes {f0,f1} into the result registers,
//   RESP holds the result until the consumer accepts it.
//   Ports:
//     clock, reset (sync, active-high)
//     req_valid [NUM_REQ-1:0]   in  : per-requester request
//     req_data  [7*NUM_REQ-1:0] in  : requester i operand in [7i+6:7i]
//     req_ready [NUM_REQ-1:0]   out : one-hot accept pulse
//     rsp_valid                 out : result valid, held until accepted
//     rsp_ready                 in  : consumer accept
//     rsp_id    [ID_W-1:0]      out : granted requester index
//     rsp_f0, rsp_f1            out : evaluation results
//     busy                      out : FSM not in IDLE
//     stat_count [15:0]         out : saturating handshake counter, present
//                                     only when CON1_SCHED_STATS_EN is defined
// ----------------------------------------------------------------------------
module con1_eval_sched
  import con1_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [7*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_f0,
  output logic                 rsp_f1,
  output logic                 busy
`ifdef CON1_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_count
`endif
);

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic            any;
  logic [ID_W-1:0] grant_idx;
  logic            grant;
  logic            rsp_hs;
  logic [6:0]      op_p0;
  logic [ID_W-1:0] id_p0;

  con1_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .any       (any),
    .grant_idx (grant_idx)
  );

  // No grant may be issued in a reset cycle.
  assign grant  = (state == IDLE) && any && !reset;
  assign rsp_hs = rsp_valid && rsp_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Stage p0: operand and ID captured in the grant cycle only.
  always_ff @(posedge clock) begin
    if (grant) begin
      op_p0 <= req_data[7*grant_idx +: 7];
      id_p0 <= grant_idx;
    end
  end

  // Result stage: loaded in EVAL, held through RESP until accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_f0    <= 1'b0;
      rsp_f1    <= 1'b0;
    end else if (state == EVAL) begin
      {rsp_f0, rsp_f1} <= con1_eval(op_p0);
      rsp_id           <= id_p0;
      rsp_valid        <= 1'b1;
    end else if ((state == RESP) && rsp_hs) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef CON1_SCHED_STATS_EN
  logic [15:0] stat_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_cnt <= '0;
    end else if (rsp_hs && (stat_cnt != 16'hFFFF)) begin
      stat_cnt <= stat_cnt + 16'd1;
    end
  end

  assign stat_count = stat_cnt;
`endif

endmodule

// File: tb/tb_con1_eval_sched.sv
// ----------------------------------------------------------------------------
// tb_con1_eval_sched
//   Self-checking bench for con1_eval_sched. A transaction-level model tracks
//   the outstanding request (grant time, ID, expected results), the
//   round-robin pointer and the handshake count; every cycle the DUT outputs
//   are compared against it. Directed scenarios are followed by randomized
//   traffic. Define CON1_SCHED_STATS_EN to include the counter scenario.
// ----------------------------------------------------------------------------
module tb_con1_eval_sched;

  localparam int N  = 4;
  localparam int IW = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [7*N-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic             rsp_f0;
  logic             rsp_f1;
  logic             busy;
`ifdef CON1_SCHED_STATS_EN
  logic [15:0]      stat_count;
`endif

  con1_eval_sched #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_f0    (rsp_f0),
    .rsp_f1    (rsp_f1),
    .busy      (busy)
`ifdef CON1_SCHED_STATS_EN
    ,
    .stat_count(stat_count)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference equations written on the named operand fields.
  function automatic logic [1:0] ref_f(input logic [6:0] op);
    logic a, b, c, d, f, g, h;
    logic r0, r1;
    {a, b, c, d, f, g, h} = op;
    r0 = (a && b) || (!b && !c && d) || (c && d && f) || (b && h && !f);
    r1 = (!a && !b) || (!a && f) || (a && b && !f) || (!f && !g) || (f && !b && !d);
    return {r0, r1};
  endfunction

  // Model state: one outstanding transaction at most.
  bit m_out;        // a request has been granted and not yet accepted
  int m_age;        // cycles elapsed since the grant edge
  int m_rr;         // next highest-priority requester
  int m_id;
  bit m_f0, m_f1;
  bit m_after_rst;
  int m_cnt;

  // One clock cycle: apply inputs, compare outputs, advance the model.
  task automatic step(input bit rst, input logic [N-1:0] v, input logic [7*N-1:0] d,
                      input bit rdy, output int gnt);
    bit           exp_rv;
    int           exp_g;
    logic [N-1:0] exp_ready;
    reset     = rst;
    req_valid = v;
    req_data  = d;
    rsp_ready = rdy;
    #1;
    exp_rv = m_out && (m_age >= 1);
    exp_g  = -1;
    if (!m_out && !rst) begin
      for (int k = 0; k < N; k++) begin
        if (exp_g < 0 && v[(m_rr + k) % N]) exp_g = (m_rr + k) % N;
      end
    end
    exp_ready = '0;
    if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
    chk("busy", busy, m_out);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("req_ready", req_ready, exp_ready);
    if (exp_rv) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_f0", rsp_f0, m_f0);
      chk("rsp_f1", rsp_f1, m_f1);
    end
    if (m_after_rst) begin
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_f", {rsp_f0, rsp_f1}, 0);
    end
`ifdef CON1_SCHED_STATS_EN
    chk("stat_count", stat_count, m_cnt);
`endif
    gnt = exp_g;
    if (rst) begin
      m_out       = 0;
      m_rr        = 0;
      m_after_rst = 1;
      m_cnt       = 0;
    end else begin
      m_after_rst = 0;
      if (m_out) begin
        if (exp_rv && rdy) begin
          m_out = 0;
          if (m_cnt < 'hFFFF) m_cnt++;
        end else begin
          m_age++;
        end
      end else if (exp_g >= 0) begin
        m_out         = 1;
        m_age         = 0;
        m_id          = exp_g;
        {m_f0, m_f1}  = ref_f(d[7*exp_g +: 7]);
        m_rr          = (exp_g + 1) % N;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    int             g;
    logic [7*N-1:0] d;
    int             gq[$];
    int             cq[$];
    int             order[5];
    order = '{0, 1, 2, 3, 0};

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    m_out = 0; m_age = 0; m_rr = 0; m_id = 0; m_f0 = 0; m_f1 = 0;
    m_after_rst = 1; m_cnt = 0;

    // Scenario 1: requester 0, a=b=1.
    d = '0; d[6:0] = 7'b1100000;
    step(0, 4'b0001, d, 1, g);
    step(0, 4'b0000, '0, 1, g);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_f0", rsp_f0, 1);
    chk("t1_f1", rsp_f1, 1);
    step(0, 4'b0000, '0, 1, g);

    // Scenario 2: requester 2 with d only, then a,f,g.
    d = '0; d[20:14] = 7'b0001000;
    step(0, 4'b0100, d, 1, g);
    d = '0;   // later data changes must not matter
    step(0, 4'b0000, 28'hFFFFFFF, 1, g);
    chk("t2_f0", rsp_f0, 1);
    chk("t2_f1", rsp_f1, 1);
    step(0, 4'b0000, '0, 1, g);
    d = '0; d[20:14] = 7'b1000110;
    for (int i = 0; i < 4; i++) step(0, (i == 0) ? 4'b0100 : 4'b0000, d, 1, g);

    // Scenario 3: all requesters valid after reset, consumer always ready.
    step(1, 4'b1111, '0, 1, g);
    for (int i = 0; i < 15; i++) begin
      step(0, 4'b1111, 28'(i * 32'h0123457), 1, g);
      if (g >= 0) begin
        gq.push_back(g);
        cq.push_back(i);
      end
    end
    chk("t3_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      chk("t3_order", gq[i], order[i]);
      if (i > 0) chk("t3_gap", cq[i] - cq[i-1], 3);
    end

    // Scenario 4: consumer stalls for 5 cycles while requests stay high.
    step(0, 4'b0000, '0, 1, g);
    step(0, 4'b0000, '0, 1, g);
    step(0, 4'b0100, 28'h5A5A5A5, 0, g);
    step(0, 4'b1111, 28'h1234567, 0, g);
    for (int i = 0; i < 5; i++) step(0, 4'b1111, 28'($urandom), 0, g);
    step(0, 4'b1111, 28'h7654321, 1, g);
    step(0, 4'b1111, 28'h0F0F0F0, 1, g);
    chk("t4_regrant", (g >= 0), 1);
    for (int i = 0; i < 3; i++) step(0, 4'b0000, '0, 1, g);

    // Scenario 5: reset during EVAL, then requesters 3 and 0 together.
    step(0, 4'b0010, 28'h3C3C3C3, 1, g);
    step(1, 4'b0000, '0, 1, g);
    chk("t5_valid", rsp_valid, 0);
    chk("t5_busy", busy, 0);
    step(0, 4'b1001, 28'h2468ACE, 1, g);
    for (int i = 0; i < 3; i++) step(0, 4'b0000, '0, 1, g);

`ifdef CON1_SCHED_STATS_EN
    // Scenario 6: handshake counter and saturation.
    step(1, 4'b0000, '0, 1, g);
    for (int i = 0; i < 9; i++) step(0, 4'b0001, 28'($urandom), 1, g);
    chk("t6_cnt3", stat_count, 3);
    force dut.stat_cnt = 16'hFFFF;
    #1;
    release dut.stat_cnt;
    m_cnt = 'hFFFF;
    for (int i = 0; i < 3; i++) step(0, 4'b0001, 28'($urandom), 1, g);
    chk("t6_sat", stat_count, 16'hFFFF);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit           r;
      logic [N-1:0] v;
      bit           rdy;
      r   = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      step(r, v, 28'($urandom), rdy, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
